pspin_cmd_tracker: RTL

Per-cluster command-slot tracker between the NUM_CORES HPU drivers and the cluster's command port toward the SoC command unit. It generalises the fixed 4-cluster/8-core/4-command ID scheme into a parametrised allocator. For each accepted core request it:
- allocates a free local command ID,
- stamps the full `pspin_cmd_id_t` and forwards the request through a round-robin arbiter,
- frees the slot when the matching response returns.

It also reports completions back to the issuing core only when `generate_event` was set.

---
 rtl/pspin_cmd_pkg.sv | 32 +++
 rtl/pspin_cmd_slot_alloc.sv | 68 ++++++
 rtl/pspin_cmd_tracker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pspin_cmd_pkg.sv
// Shared command types for the per-cluster command tracker.
// The command ID is built from cluster, core and local slot fields.
package pspin_cmd_pkg;

    localparam int unsigned NUM_CLUSTERS    = 4;
    localparam int unsigned PSPIN_NUM_CORES = 8;
    localparam int unsigned PSPIN_NUM_CMDS  = 4;

    localparam int unsigned CLUSTER_ID_W =
        (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int unsigned CORE_W =
        (PSPIN_NUM_CORES > 1) ? $clog2(PSPIN_NUM_CORES) : 1;
    localparam int unsigned CMD_W = $clog2(PSPIN_NUM_CMDS);

    typedef struct packed {
        logic [CLUSTER_ID_W-1:0] cluster_id;
        logic [CORE_W-1:0]       core_id;
        logic [CMD_W-1:0]        local_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
        logic          generate_event;
        logic [1:0]    cmd_type;
        logic [31:0]   payload;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t cmd_id;
    } pspin_cmd_resp_t;

endpackage

// File: rtl/pspin_cmd_slot_alloc.sv
// Per-core slot bitmaps: lowest-free allocation, release on response,
// and a registered outstanding-command count.
module pspin_cmd_slot_alloc
    import pspin_cmd_pkg::*;
#(
    parameter int unsigned NUM_CMDS = PSPIN_NUM_CMDS,
    parameter int unsigned CMD_ID_W = $clog2(NUM_CMDS),
    parameter int unsigned CNT_W    = $clog2(NUM_CMDS) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic                alloc_event_i,
    input  logic                free_i,
    input  logic [CMD_ID_W-1:0] free_slot_i,
    output logic                full_o,
    output logic [CMD_ID_W-1:0] alloc_slot_o,
    output logic                slot_busy_o,
    output logic                slot_event_o,
    output logic [CNT_W-1:0]    inflight_o
);

    logic [NUM_CMDS-1:0] busy_q, busy_d;
    logic [NUM_CMDS-1:0] event_q, event_d;
    logic [CNT_W-1:0]    cnt_d;

    always_comb begin
        alloc_slot_o = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_slot_o = CMD_ID_W'(i);
        end
    end

    assign full_o       = &busy_q;
    assign slot_busy_o  = busy_q[free_slot_i];
    assign slot_event_o = event_q[free_slot_i];

    // Allocation picks from the pre-free bitmap, so both edits never collide
    always_comb begin
        busy_d  = busy_q;
        event_d = event_q;
        if (free_i) busy_d[free_slot_i] = 1'b0;
        if (alloc_i) begin
            busy_d[alloc_slot_o]  = 1'b1;
            event_d[alloc_slot_o] = alloc_event_i;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            event_q    <= '0;
            inflight_o <= '0;
        end else begin
            busy_q     <= busy_d;
            event_q    <= event_d;
            inflight_o <= cnt_d;
        end
    end

endmodule

// File: rtl/pspin_cmd_tracker.sv
// Cluster command tracker: round-robin issue with slot stamping,
// response decode, completion events and error pulses.
module pspin_cmd_tracker
    import pspin_cmd_pkg::*;
#(
    parameter int unsigned NUM_CORES = PSPIN_NUM_CORES,
    parameter int unsigned NUM_CMDS  = PSPIN_NUM_CMDS,
    parameter int unsigned CMD_ID_W  = $clog2(NUM_CMDS),
    parameter int unsigned CORE_ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int unsigned CNT_W     = $clog2(NUM_CMDS) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [CLUSTER_ID_W-1:0]             cluster_id_i,
    input  logic [NUM_CORES-1:0]                core_req_valid_i,
    output logic [NUM_CORES-1:0]                core_req_ready_o,
    input  pspin_cmd_req_t [NUM_CORES-1:0]      core_req_i,
    output logic [NUM_CORES-1:0][CMD_ID_W-1:0]  core_issued_id_o,
    output logic                                cmd_valid_o,
    input  logic                                cmd_ready_i,
    output pspin_cmd_req_t                      cmd_o,
    input  logic                                resp_valid_i,
    input  pspin_cmd_resp_t                     resp_i,
    output logic [NUM_CORES-1:0]                core_cpl_valid_o,
    output logic [NUM_CORES-1:0][CMD_ID_W-1:0]  core_cpl_id_o,
    output logic [NUM_CORES-1:0][CNT_W-1:0]     core_inflight_o,
    output logic                                err_o
);

    logic [NUM_CORES-1:0] full, eligible, free;
    logic [NUM_CORES-1:0] slot_busy, slot_event;
    logic [CORE_ID_W-1:0] ptr_q, winner;
    logic                 found, out_free, issue;
    logic [CORE_W-1:0]    r_core;
    logic [CMD_W-1:0]     r_slot;
    logic                 core_ok, hit;
    pspin_cmd_req_t       cmd_d;

    assign eligible = core_req_valid_i & ~full;
    assign out_free = !cmd_valid_o || cmd_ready_i;

    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CORES;
            if (!found && eligible[idx[CORE_ID_W-1:0]]) begin
                found  = 1'b1;
                winner = CORE_ID_W'(idx);
            end
        end
    end

    assign issue = found && out_free;

    always_comb begin
        core_req_ready_o = '0;
        if (issue) core_req_ready_o[winner] = 1'b1;
    end

    always_comb begin
        cmd_d                   = core_req_i[winner];
        cmd_d.cmd_id.cluster_id = cluster_id_i;
        cmd_d.cmd_id.core_id    = CORE_W'(winner);
        cmd_d.cmd_id.local_id   = core_issued_id_o[winner];
    end

    assign r_core  = resp_i.cmd_id.core_id;
    assign r_slot  = resp_i.cmd_id.local_id;
    assign core_ok = {1'b0, r_core} < (CORE_W + 1)'(NUM_CORES);
    assign hit     = resp_valid_i && core_ok && slot_busy[r_core]
                  && (resp_i.cmd_id.cluster_id == cluster_id_i);

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
        assign free[c] = hit && (r_core == CORE_W'(c));

        pspin_cmd_slot_alloc #(
            .NUM_CMDS (NUM_CMDS),
            .CMD_ID_W (CMD_ID_W),
            .CNT_W    (CNT_W)
        ) u_alloc (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .alloc_i       (core_req_ready_o[c]),
            .alloc_event_i (core_req_i[c].generate_event),
            .free_i        (free[c]),
            .free_slot_i   (r_slot),
            .full_o        (full[c]),
            .alloc_slot_o  (core_issued_id_o[c]),
            .slot_busy_o   (slot_busy[c]),
            .slot_event_o  (slot_event[c]),
            .inflight_o    (core_inflight_o[c])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_valid_o      <= 1'b0;
            cmd_o            <= '0;
            ptr_q            <= '0;
            err_o            <= 1'b0;
            core_cpl_valid_o <= '0;
            core_cpl_id_o    <= '0;
        end else begin
            if (issue) begin
                cmd_valid_o <= 1'b1;
                cmd_o       <= cmd_d;
                ptr_q       <= (winner == CORE_ID_W'(NUM_CORES - 1))
                             ? '0 : winner + 1'b1;
            end else if (cmd_ready_i) begin
                cmd_valid_o <= 1'b0;
            end
            err_o <= resp_valid_i && !hit;
            for (int c = 0; c < NUM_CORES; c++) begin
                core_cpl_valid_o[c] <= free[c] && slot_event[c];
                if (free[c] && slot_event[c]) core_cpl_id_o[c] <= r_slot;
            end
        end
    end

endmodule
